// File: rtl/dco_period_meter_if.sv
// -----------------------------------------------------------------------------
// dco_period_meter_if
//
// Purpose : groups the measurement-side signals of dco_period_meter into one
//           bundle. The system clock and reset stay plain module ports.
//
// Signals :
//   ena          master -> slave   measurement enable (low = synchronous clear)
//   dco_in       master -> slave   raw DCO square wave, asynchronous to clk
//   last_period  slave  -> master  most recent single-period measurement
//   period_avg   slave  -> master  floor mean of the last completed group
//   avg_valid    slave  -> master  one-cycle strobe when period_avg updates
//   timeout      slave  -> master  sticky loss-of-oscillation flag
//
// Modports:
//   master : the side that drives enable / DCO and consumes results
//   slave  : the period meter itself
// -----------------------------------------------------------------------------
interface dco_period_meter_if #(
    parameter int CNT_W = 12
);
    logic             ena;
    logic             dco_in;
    logic [CNT_W-1:0] last_period;
    logic [CNT_W-1:0] period_avg;
    logic             avg_valid;
    logic             timeout;

    modport master (
        output ena,
        output dco_in,
        input  last_period,
        input  period_avg,
        input  avg_valid,
        input  timeout
    );

    modport slave (
        input  ena,
        input  dco_in,
        output last_period,
        output period_avg,
        output avg_valid,
        output timeout
    );
endinterface

// File: rtl/dco_period_meter.sv
// -----------------------------------------------------------------------------
// dco_period_meter
//
// Purpose : measures the period of the on-chip DCO output in system clock
//           cycles. The DCO wave is synchronised (s1 -> s2, s3 = s2 delayed),
//           each rising edge to rising edge interval is counted, groups of
//           2^AVG_LOG2 periods are averaged (floor), and loss of oscillation
//           is flagged after TIMEOUT+1 cycles without an edge.
//
// Parameters:
//   CNT_W     width of the period counter and of every period output
//   AVG_LOG2  log2 of the number of periods per averaged result (1..4)
//   TIMEOUT   edge-free cycles tolerated; must be <= 2^CNT_W - 1
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of dco_period_meter_if:
//            ena, dco_in                              (inputs)
//            last_period, period_avg, avg_valid, timeout (registered outputs)
// -----------------------------------------------------------------------------
module dco_period_meter #(
    parameter int CNT_W    = 12,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    dco_period_meter_if.slave   bus
);

    // Accumulator holds the sum of up to 2^AVG_LOG2 samples without overflow.
    localparam int ACC_W = CNT_W + AVG_LOG2;

    localparam logic [AVG_LOG2-1:0] IDX_LAST  = {AVG_LOG2{1'b1}};
    localparam logic [AVG_LOG2-1:0] IDX_ONE   = AVG_LOG2'(1'b1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

    // Floor mean of a completed group: drop the low AVG_LOG2 bits of the sum.
    function automatic logic [CNT_W-1:0] group_mean(input logic [ACC_W-1:0] total);
        logic [ACC_W-1:0] shifted;
        shifted = total >> AVG_LOG2;
        return shifted[CNT_W-1:0];
    endfunction

    // Synchroniser / edge-detect flops
    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_s;

    // Measurement state
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [ACC_W-1:0]    acc_q,   acc_d;
    logic [AVG_LOG2-1:0] idx_q,   idx_d;

    // Output registers
    logic [CNT_W-1:0]    last_q,  last_d;
    logic [CNT_W-1:0]    avg_q,   avg_d;
    logic                valid_q, valid_d;
    logic                to_q,    to_d;

    // Datapath helpers
    logic [CNT_W-1:0]    sample_s;
    logic [ACC_W-1:0]    sum_s;

    // Two-flop synchroniser plus one delay stage for edge detection; these run
    // regardless of ena so the edge history is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.dco_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_s = s2_q & ~s3_q;

    // The counter was cleared on the previous edge, so the interval is cnt+1.
    assign sample_s = cnt_q + CNT_ONE;
    assign sum_s    = acc_q + {{AVG_LOG2{1'b0}}, sample_s};

    // State, counter, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            to_q    <= to_d;
        end
    end

    // Next-state and datapath logic of the IDLE/MEAS measurement machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        last_d  = last_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        to_d    = to_q;

        if (!bus.ena) begin
            // Disabled: drop back to IDLE and discard the partial group, but
            // keep the published results and the sticky flag.
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The first edge only opens a measurement window.
                    cnt_d = '0;
                    if (rise_s) begin
                        state_d = ST_MEAS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_MEAS: begin
                    // An edge takes priority over an expiring timeout, so an
                    // interval of exactly TIMEOUT+1 is still a valid sample.
                    if (rise_s) begin
                        last_d = sample_s;
                        cnt_d  = '0;
                        if (idx_q == IDX_LAST) begin
                            avg_d   = group_mean(sum_s);
                            valid_d = 1'b1;
                            to_d    = 1'b0;
                            acc_d   = '0;
                            idx_d   = '0;
                        end else begin
                            acc_d = sum_s;
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = ST_IDLE;
                        to_d    = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign bus.last_period = last_q;
    assign bus.period_avg  = avg_q;
    assign bus.avg_valid   = valid_q;
    assign bus.timeout     = to_q;

endmodule

// File: tb/tb_dco_period_meter.sv
`timescale 1ns/1ps
module tb_dco_period_meter;

    localparam int CNT_W    = 12;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 1023;
    localparam int NAVG     = 4;
    localparam int MAXC     = 65536;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dco_period_meter_if #(.CNT_W(CNT_W)) bus ();

    dco_period_meter #(
        .CNT_W    (CNT_W),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   valid_seen = 0;
    logic ena_g      = 1'b1;

    // DCO value as seen by the synchroniser input, indexed by the cycle it was
    // driven in (forced to 0 while the synchroniser is held in reset).
    logic hist [0:MAXC-1];

    // Reference model: timestamps of edges and a queue of completed periods.
    bit               armed;
    int               last_rise;
    int               grp[$];
    logic [CNT_W-1:0] exp_last;
    logic [CNT_W-1:0] exp_avg;
    logic             exp_valid;
    logic             exp_to;

    function automatic void model_clear();
        armed     = 1'b0;
        last_rise = 0;
        grp.delete();
        exp_last  = '0;
        exp_avg   = '0;
        exp_valid = 1'b0;
        exp_to    = 1'b0;
    endfunction

    // Expected state just after clock edge number cyc. A DCO rise driven in
    // cycle n reaches the measurement logic at edge n+3.
    function automatic void model_step();
        logic r;
        int   p;
        int   sum;
        if (rst_n !== 1'b1) begin
            model_clear();
            return;
        end
        exp_valid = 1'b0;
        r = (cyc >= 4) && (hist[cyc-3] === 1'b1) && (hist[cyc-4] === 1'b0);
        if (bus.ena !== 1'b1) begin
            armed = 1'b0;
            grp.delete();
        end else if (r) begin
            if (armed) begin
                p        = cyc - last_rise;
                exp_last = CNT_W'(p);
                grp.push_back(p);
                if (grp.size() == NAVG) begin
                    sum = 0;
                    foreach (grp[i]) sum += grp[i];
                    exp_avg   = CNT_W'(sum / NAVG);
                    exp_valid = 1'b1;
                    exp_to    = 1'b0;
                    grp.delete();
                end
            end
            armed     = 1'b1;
            last_rise = cyc;
        end else if (armed && (cyc - last_rise == TIMEOUT + 1)) begin
            exp_to = 1'b1;
            armed  = 1'b0;
            grp.delete();
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    // One clock cycle: advance the model at the edge, drive inputs, check at negedge.
    task automatic tick(input logic dco_v, input logic ena_v, input logic rstn_v);
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        model_step();
        #1;
        bus.dco_in = dco_v;
        bus.ena    = ena_v;
        rst_n      = rstn_v;
        hist[cyc]  = rstn_v ? dco_v : 1'b0;
        if (!rstn_v) model_clear();
        @(negedge clk);
        chk("last_period", 32'(bus.last_period), 32'(exp_last));
        chk("period_avg",  32'(bus.period_avg),  32'(exp_avg));
        chk("avg_valid",   32'(bus.avg_valid),   32'(exp_valid));
        chk("timeout",     32'(bus.timeout),     32'(exp_to));
        if (bus.avg_valid === 1'b1) valid_seen++;
    endtask

    task automatic drive(input logic dco_v, input int n);
        for (int i = 0; i < n; i++) tick(dco_v, ena_g, 1'b1);
    endtask

    // One DCO period: high for hi cycles, then low for the remainder of p.
    task automatic pulse(input int p, input int hi);
        drive(1'b1, hi);
        drive(1'b0, p - hi);
    endtask

    // Reset pulse between two clock edges; called at a negedge.
    task automatic async_reset_pulse();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_last_period", 32'(bus.last_period), 32'd0);
        chk("rst_period_avg",  32'(bus.period_avg),  32'd0);
        chk("rst_avg_valid",   32'(bus.avg_valid),   32'd0);
        chk("rst_timeout",     32'(bus.timeout),     32'd0);
        model_clear();
        for (int i = 1; i <= 3; i++) begin
            if (cyc - i >= 0) hist[cyc-i] = 1'b0;
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int v0;
        int p;
        int mode;
        for (int i = 0; i < MAXC; i++) hist[i] = 1'b0;
        model_clear();
        bus.dco_in = 1'b0;
        bus.ena    = 1'b0;
        rst_n      = 1'b0;

        // Reset held with the DCO toggling
        for (int i = 0; i < 10; i++) tick(logic'(i % 2), 1'b1, 1'b0);
        chk("reset_last",  32'(bus.last_period), 32'd0);
        chk("reset_avg",   32'(bus.period_avg),  32'd0);
        chk("reset_to",    32'(bus.timeout),     32'd0);
        chk("reset_valid", 32'(valid_seen),      32'd0);
        tick(1'b0, 1'b1, 1'b1);
        drive(1'b0, 5);
        chk("post_reset_last", 32'(bus.last_period), 32'd0);
        chk("post_reset_avg",  32'(bus.period_avg),  32'd0);

        // Steady period-22 wave followed by varying periods
        for (int i = 0; i < 8; i++) pulse(22, 11);
        pulse(20, 10);
        chk("steady_valid_count", 32'(valid_seen),      32'd2);
        chk("steady_avg",         32'(bus.period_avg),  32'd22);
        chk("steady_last",        32'(bus.last_period), 32'd22);
        pulse(22, 11);
        pulse(24, 12);
        pulse(26, 13);
        pulse(21, 10);
        chk("vary_avg_23",  32'(bus.period_avg),  32'd23);
        chk("vary_last_26", 32'(bus.last_period), 32'd26);
        pulse(21, 11);
        pulse(21, 10);
        pulse(22, 11);
        drive(1'b1, 5);
        drive(1'b0, 5);
        chk("vary_avg_21", 32'(bus.period_avg),  32'd21);
        chk("vary_last",   32'(bus.last_period), 32'd22);

        // Loss of oscillation, then recovery
        drive(1'b0, 1100);
        chk("timeout_set",  32'(bus.timeout),     32'd1);
        chk("timeout_last", 32'(bus.last_period), 32'd22);
        for (int i = 0; i < 4; i++) pulse(22, 11);
        chk("timeout_sticky", 32'(bus.timeout), 32'd1);
        pulse(22, 11);
        chk("timeout_cleared", 32'(bus.timeout),    32'd0);
        chk("resume_avg",      32'(bus.period_avg), 32'd22);

        // Enable dropped mid-group
        pulse(22, 11);
        pulse(22, 11);
        v0 = valid_seen;
        ena_g = 1'b0;
        drive(1'b0, 10);
        ena_g = 1'b1;
        chk("ena_no_valid", 32'(valid_seen),      32'(v0));
        chk("ena_hold_avg", 32'(bus.period_avg),  32'd22);
        for (int i = 0; i < 4; i++) pulse(22, 11);
        chk("ena_restart_pending", 32'(valid_seen), 32'(v0));
        pulse(22, 11);
        chk("ena_restart_done", 32'(valid_seen), 32'(v0 + 1));

        // Asynchronous reset in the middle of a period
        pulse(22, 11);
        pulse(22, 11);
        drive(1'b1, 11);
        drive(1'b0, 5);
        async_reset_pulse();
        drive(1'b0, 6);
        v0 = valid_seen;
        for (int i = 0; i < 4; i++) pulse(22, 11);
        chk("rst_avg_pending", 32'(bus.period_avg), 32'd0);
        pulse(22, 11);
        chk("rst_avg_22",  32'(bus.period_avg), 32'd22);
        chk("rst_valid_1", 32'(valid_seen),     32'(v0 + 1));

        // Edge arriving exactly when the counter reaches TIMEOUT: edge wins
        pulse(22, 11);
        pulse(TIMEOUT + 1, 3);
        pulse(22, 11);
        chk("edge_at_timeout_last", 32'(bus.last_period), 32'(TIMEOUT + 1));
        chk("edge_at_timeout_flag", 32'(bus.timeout),     32'd0);

        // Randomised periods, enable drops and long gaps
        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 19));
            if (mode == 0) begin
                drive(1'b0, int'($urandom_range(1000, 1040)));
            end else if (mode == 1) begin
                ena_g = 1'b0;
                drive(1'b0, int'($urandom_range(1, 15)));
                ena_g = 1'b1;
            end else begin
                p = int'($urandom_range(2, 40));
                pulse(p, int'($urandom_range(1, p - 1)));
            end
        end
        drive(1'b0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dco_period_meter.md
# dco_period_meter

Downstream measurement stage for the on-chip DCO output. Synchronises the DCO square wave into the system clock domain and measures each full period (rising edge to rising edge) in `clk` cycles. Averages groups of 2^AVG_LOG2 periods and reports the result with a one-cycle valid strobe. Flags loss of oscillation with a timeout, so the DCO control code can be characterised or closed-loop trimmed from the measured value.

## Interface
- `CNT_W`, 12: width of the period counter and of every period output.
- `AVG_LOG2`, 2: log2 of the number of periods averaged per result (1..4).
- `TIMEOUT`, 1023: cycles without a rising edge before declaring loss of oscillation; must be at most 2^CNT_W − 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  measurement enable; low acts as a synchronous clear of measurement state.
- `dco_in`  in  1  DCO square wave, asynchronous to `clk` in general.
- `last_period`  out  CNT_W  most recent single-period measurement, in cycles.
- `period_avg`  out  CNT_W  mean of the last completed group of 2^AVG_LOG2 periods (floor).
- `avg_valid`  out  1  one-cycle pulse when `period_avg` updates.
- `timeout`  out  1  sticky loss-of-oscillation flag.

## Operation
- **Synchroniser and edge detect:** `dco_in` passes through `s1` → `s2`, and `s3` is `s2` delayed one cycle. `rise = s2 & ~s3`. All three flops reset to 0.
- **State machine:** two states, IDLE and MEAS. Reset state is IDLE.
  - IDLE: counter held at 0. The first `rise` while `ena` is high moves to MEAS and zeroes the counter. This first edge produces no sample.
  - MEAS, no `rise`: the counter increments by 1.
  - MEAS, on `rise`: sample = counter + 1, captured into `last_period`; the counter is set to 0; the sample is added to the accumulator and the sample index increments.
  - MEAS, counter reaches TIMEOUT with no `rise`: go to IDLE, set `timeout`, clear the accumulator and sample index.
- **Averaging:**
  - The accumulator is CNT_W+AVG_LOG2 bits wide.
  - On the 2^AVG_LOG2-th sample, `period_avg` = (acc + sample) >> AVG_LOG2 and `avg_valid` pulses. The accumulator and index then clear in the same cycle.
- **Timeout flag:** sticky. It clears only on reset or on the next `avg_valid`.
- **`ena` low:**
  - Forces IDLE and clears the counter, accumulator and index next cycle.
  - Synchroniser flops keep running.
  - `last_period`, `period_avg` and `timeout` hold their values. `avg_valid` is 0.
- **Simultaneous `rise` and counter == TIMEOUT:** `rise` wins; the sample is taken and no timeout occurs.
- **Reset values:** `last_period` 0, `period_avg` 0, `avg_valid` 0, `timeout` 0. State IDLE, counter, accumulator and index 0.

## Timing
- Fully synchronous to posedge `clk` except for `rst_n`.
- Latency: a `dco_in` rise sampled by `s1` at edge k updates `last_period` at edge k+2. On the group-closing sample, `period_avg` and `avg_valid` update at that same edge k+2.
- `avg_valid` is high for exactly one cycle per completed group, never on consecutive cycles.
- The minimum measurable period is 2 cycles; faster inputs alias and are not supported.
- A DCO with half-period H cycles measures 2H.
- Asserting `rst_n` mid-measurement clears everything immediately. After release, the first `rise` is again a start edge only.
- The timeout fires at the edge where the counter would exceed TIMEOUT, i.e. TIMEOUT+1 cycles after the last `rise`.

## Test plan
- **Reset:** hold `rst_n` low with `dco_in` toggling → all outputs 0, no `avg_valid`. Release, wait 5 cycles with `dco_in` = 0 → outputs still 0.
- **Steady wave:** `ena`=1, `dco_in` square wave with half-period 11 (period 22) → first start edge gives no sample; `last_period` = 22 from the second edge. `avg_valid` pulses every 88 cycles with `period_avg` = 22.
- **Varying periods:** periods 20, 22, 24, 26 → `last_period` steps 20/22/24/26 and `period_avg` = 23. Then periods 21, 21, 21, 22 → `period_avg` = 21 (85>>2, floor).
- **Timeout:** after lock, hold `dco_in` low → `timeout` rises 1024 cycles after the last rise and `last_period` holds. Resume a period-22 wave → `timeout` clears at the next `avg_valid`, which comes 4 samples after the restart edge.
- **`ena` drop:** drop `ena` for 10 cycles after 2 samples of a group → no `avg_valid`, outputs hold. After re-enable, one start edge plus 4 samples are needed before `avg_valid`.
- **Async reset mid-run:** pulse `rst_n` low between clock edges mid-period → outputs 0 immediately. The next group is measured correctly (`period_avg` = 22 for a period-22 wave).
